// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS controller: sequences fetch, decode, execute, memory
// and write-back for a shared-memory datapath, with a memory wait watchdog
// and sticky error flags.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | request instruction at PC; latch IR and advance PC on ready
// DECODE | classify op/funct; nop returns, unknown encodings trap
// EXEC   | drive ALU; branches/jumps resolve here and return to FETCH
// MEM    | data access at ALU result; lw continues to WB, sw returns
// WB     | single-cycle GRF write of ALU result or MDR
// ERROR  | absorbing trap for illegal instruction or watchdog expiry
module multi_cycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_equal,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_is_instr,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       ext_sign,
  output logic       alu_b_sel,
  output logic [4:0] alu_ctrl,
  output logic       grf_we,
  output logic [1:0] grf_wa_sel,
  output logic [1:0] grf_wd_sel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  typedef enum logic [2:0] {
    stFetch  = 3'd0,
    stDecode = 3'd1,
    stExec   = 3'd2,
    stMem    = 3'd3,
    stWb     = 3'd4,
    stError  = 3'd7
  } stateT;

  // Watchdog counter is at least 8 bits; widen only for larger limits.
  localparam int CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  stateT curState, nextState;
  logic [CntW-1:0] waitCnt, waitCntInc;
  logic isWaiting, wdExpire, setIllegal;

  logic isRtype, isAddu, isSubu, isJr, isNop;
  logic isOri, isLui, isLw, isSw, isBeq, isJal, isLegal;

  // Instruction classification; op/funct stay valid from DECODE to the next fetch.
  always_comb begin
    isRtype = (op == 6'b000000);
    isAddu  = isRtype && (funct == 6'b100001);
    isSubu  = isRtype && (funct == 6'b100011);
    isJr    = isRtype && (funct == 6'b001000);
    isNop   = isRtype && (funct == 6'b000000);
    isOri   = (op == 6'b001101);
    isLui   = (op == 6'b001111);
    isLw    = (op == 6'b100011);
    isSw    = (op == 6'b101011);
    isBeq   = (op == 6'b000100);
    isJal   = (op == 6'b000011);
    isLegal = isAddu | isSubu | isJr | isOri | isLui | isLw | isSw | isBeq | isJal;
  end

  // Watchdog: a wait cycle is any FETCH/MEM cycle without mem_ready.
  always_comb begin
    isWaiting  = ((curState == stFetch) || (curState == stMem)) && !mem_ready;
    waitCntInc = (waitCnt == '1) ? waitCnt : waitCnt + CntW'(1);
    wdExpire   = isWaiting && (TIMEOUT_CYCLES != 0) && (waitCntInc >= TimeoutVal);
  end

  // Counter is zero whenever FETCH/MEM is entered because it clears outside wait cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (isWaiting) begin
      waitCnt <= waitCntInc;
    end else begin
      waitCnt <= '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState <= stFetch;
    end else begin
      curState <= nextState;
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (setIllegal) illegal <= 1'b1;
      if (wdExpire)   timeout <= 1'b1;
    end
  end

  // Next-state and strobe decode; everything is forced idle while reset is asserted.
  always_comb begin
    nextState    = curState;
    setIllegal   = 1'b0;
    mem_req      = 1'b0;
    mem_is_instr = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    ext_sign     = 1'b0;
    alu_b_sel    = 1'b0;
    alu_ctrl     = 5'd0;
    grf_we       = 1'b0;
    grf_wa_sel   = 2'd0;
    grf_wd_sel   = 2'd0;

    if (reset) begin
      // There is no ALU output register, so the ALU setup chosen in EXEC is
      // kept through MEM (address) and WB (write data).
      if ((curState == stExec) || (curState == stMem) || (curState == stWb)) begin
        ext_sign  = isLw | isSw | isBeq;
        alu_b_sel = isOri | isLui | isLw | isSw;
        if (isSubu || isBeq) alu_ctrl = 5'd1;
        else if (isOri)      alu_ctrl = 5'd2;
        else if (isLui)      alu_ctrl = 5'd3;
      end

      case (curState)
        stFetch: begin
          mem_req      = 1'b1;
          mem_is_instr = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 2'd0;
            nextState = stDecode;
          end else if (wdExpire) begin
            nextState = stError;
          end
        end
        stDecode: begin
          if (isNop) begin
            nextState = stFetch;
          end else if (isLegal) begin
            nextState = stExec;
          end else begin
            setIllegal = 1'b1;
            nextState  = stError;
          end
        end
        stExec: begin
          nextState = stWb;
          if (isLw || isSw) begin
            nextState = stMem;
          end else if (isBeq) begin
            pc_we     = alu_equal;
            pc_sel    = 2'd1;
            nextState = stFetch;
          end else if (isJal) begin
            // GRF captures the already-advanced PC at the same edge PC jumps.
            pc_we      = 1'b1;
            pc_sel     = 2'd2;
            grf_we     = 1'b1;
            grf_wa_sel = 2'd2;
            grf_wd_sel = 2'd2;
            nextState  = stFetch;
          end else if (isJr) begin
            pc_we     = 1'b1;
            pc_sel    = 2'd3;
            nextState = stFetch;
          end
        end
        stMem: begin
          mem_req      = 1'b1;
          mem_is_instr = 1'b0;
          mem_we       = isSw;
          if (mem_ready) begin
            nextState = isLw ? stWb : stFetch;
          end else if (wdExpire) begin
            nextState = stError;
          end
        end
        stWb: begin
          grf_we     = 1'b1;
          grf_wa_sel = (isAddu || isSubu) ? 2'd0 : 2'd1;
          grf_wd_sel = isLw ? 2'd1 : 2'd0;
          nextState  = stFetch;
        end
        stError: begin
          nextState = stError;
        end
        default: begin
          nextState = stError;
        end
      endcase
    end
  end

  assign state = curState;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: one task per instruction class or
// scenario, plus a second instance with a short watchdog limit.
module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, rstN4;
  logic [5:0] op, funct;
  logic       aluEqual, memReady;

  logic       memReq, memIsInstr, memWe, irWe, pcWe, extSign, aluBSel, grfWe;
  logic [1:0] pcSel, grfWaSel, grfWdSel;
  logic [4:0] aluCtrl;
  logic [2:0] state;
  logic       illegal, timeout;

  logic       memReq4, memIsInstr4, memWe4, irWe4, pcWe4, extSign4, aluBSel4, grfWe4;
  logic [1:0] pcSel4, grfWaSel4, grfWdSel4;
  logic [4:0] aluCtrl4;
  logic [2:0] state4;
  logic       illegal4, timeout4;

  int nChecks = 0;
  int nErrors = 0;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(rstN), .op(op), .funct(funct), .alu_equal(aluEqual),
    .mem_ready(memReady), .mem_req(memReq), .mem_is_instr(memIsInstr),
    .mem_we(memWe), .ir_we(irWe), .pc_we(pcWe), .pc_sel(pcSel),
    .ext_sign(extSign), .alu_b_sel(aluBSel), .alu_ctrl(aluCtrl),
    .grf_we(grfWe), .grf_wa_sel(grfWaSel), .grf_wd_sel(grfWdSel),
    .state(state), .illegal(illegal), .timeout(timeout)
  );

  multi_cycle_ctrl #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .reset(rstN4), .op(op), .funct(funct), .alu_equal(aluEqual),
    .mem_ready(memReady), .mem_req(memReq4), .mem_is_instr(memIsInstr4),
    .mem_we(memWe4), .ir_we(irWe4), .pc_we(pcWe4), .pc_sel(pcSel4),
    .ext_sign(extSign4), .alu_b_sel(aluBSel4), .alu_ctrl(aluCtrl4),
    .grf_we(grfWe4), .grf_wa_sel(grfWaSel4), .grf_wd_sel(grfWdSel4),
    .state(state4), .illegal(illegal4), .timeout(timeout4)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    nChecks++;
    if (state !== 3'd0) begin nErrors++; $display("FAIL reset state: got %0d want 0", state); end
    nChecks++;
    if ({memReq, memWe, irWe, pcWe, grfWe} !== 5'b0) begin
      nErrors++; $display("FAIL reset strobes: got %b want 00000", {memReq, memWe, irWe, pcWe, grfWe});
    end
    nChecks++;
    if ({illegal, timeout} !== 2'b00) begin nErrors++; $display("FAIL reset flags: got %b want 00", {illegal, timeout}); end
    nextCycle();
    rstN = 1'b1;
    #1;
    nChecks++;
    if ({memReq, memIsInstr, state} !== {2'b11, 3'd0}) begin
      nErrors++; $display("FAIL reset release fetch: got req=%b instr=%b st=%0d want 1 1 0", memReq, memIsInstr, state);
    end
  endtask

  task automatic test_addu();
    logic [2:0] expSt [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    op = 6'h00; funct = 6'h21; memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nextCycle();
      #1;
      nChecks++;
      if (state !== expSt[i]) begin nErrors++; $display("FAIL addu state[%0d]: got %0d want %0d", i, state, expSt[i]); end
      nChecks++;
      if (grfWe !== (i == 3)) begin nErrors++; $display("FAIL addu grf_we[%0d]: got %b want %b", i, grfWe, (i == 3)); end
      if (i == 0) begin
        nChecks++;
        if ({irWe, pcWe, pcSel} !== 4'b1100) begin nErrors++; $display("FAIL addu fetch strobes: got %b want 1100", {irWe, pcWe, pcSel}); end
      end
      if (i == 2) begin
        nChecks++;
        if ({aluBSel, aluCtrl} !== 6'd0) begin nErrors++; $display("FAIL addu exec alu: got b=%b ctrl=%0d want 0 0", aluBSel, aluCtrl); end
      end
      if (i == 3) begin
        nChecks++;
        if ({grfWaSel, grfWdSel} !== 4'b0000) begin nErrors++; $display("FAIL addu wb sel: got wa=%0d wd=%0d want 0 0", grfWaSel, grfWdSel); end
      end
    end
  endtask

  task automatic test_subu();
    logic [2:0] expSt [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    op = 6'h00; funct = 6'h23; memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nextCycle();
      #1;
      nChecks++;
      if (state !== expSt[i]) begin nErrors++; $display("FAIL subu state[%0d]: got %0d want %0d", i, state, expSt[i]); end
      if (i == 2) begin
        nChecks++;
        if ({aluBSel, aluCtrl} !== {1'b0, 5'd1}) begin nErrors++; $display("FAIL subu exec alu: got b=%b ctrl=%0d want 0 1", aluBSel, aluCtrl); end
      end
    end
  endtask

  task automatic test_imm();
    logic [2:0] expSt [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [5:0] ops [2] = '{6'h0D, 6'h0F};
    logic [4:0] expCtrl [2] = '{5'd2, 5'd3};
    for (int k = 0; k < 2; k++) begin
      op = ops[k]; funct = 6'h3F; memReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) nextCycle();
        #1;
        nChecks++;
        if (state !== expSt[i]) begin nErrors++; $display("FAIL imm op=%h state[%0d]: got %0d want %0d", ops[k], i, state, expSt[i]); end
        if (i == 2) begin
          nChecks++;
          if ({aluBSel, aluCtrl} !== {1'b1, expCtrl[k]}) begin
            nErrors++; $display("FAIL imm op=%h exec alu: got b=%b ctrl=%0d want 1 %0d", ops[k], aluBSel, aluCtrl, expCtrl[k]);
          end
          if (k == 0) begin
            nChecks++;
            if (extSign !== 1'b0) begin nErrors++; $display("FAIL ori ext_sign: got %b want 0", extSign); end
          end
        end
        if (i == 3) begin
          nChecks++;
          if ({grfWe, grfWaSel, grfWdSel} !== 5'b1_01_00) begin
            nErrors++; $display("FAIL imm op=%h wb: got we=%b wa=%0d wd=%0d want 1 1 0", ops[k], grfWe, grfWaSel, grfWdSel);
          end
        end
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [2:0] expSt [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic       rdy   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    op = 6'h23; funct = 6'h00;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) nextCycle();
      memReady = rdy[i];
      #1;
      nChecks++;
      if (state !== expSt[i]) begin nErrors++; $display("FAIL lw state[%0d]: got %0d want %0d", i, state, expSt[i]); end
      if (i == 2) begin
        nChecks++;
        if ({extSign, aluBSel, aluCtrl} !== 7'b1_1_00000) begin
          nErrors++; $display("FAIL lw exec alu: got ext=%b b=%b ctrl=%0d want 1 1 0", extSign, aluBSel, aluCtrl);
        end
      end
      if (i >= 3 && i <= 6) begin
        nChecks++;
        if ({memReq, memIsInstr, memWe, irWe, aluBSel} !== 5'b10001) begin
          nErrors++; $display("FAIL lw mem[%0d]: got req/instr/we/ir/bsel=%b want 10001", i, {memReq, memIsInstr, memWe, irWe, aluBSel});
        end
      end
      if (i == 7) begin
        nChecks++;
        if ({grfWe, grfWaSel, grfWdSel} !== 5'b1_01_01) begin
          nErrors++; $display("FAIL lw wb: got we=%b wa=%0d wd=%0d want 1 1 1", grfWe, grfWaSel, grfWdSel);
        end
      end
    end
  endtask

  task automatic test_sw();
    logic [2:0] expSt [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    op = 6'h2B; funct = 6'h00; memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nextCycle();
      #1;
      nChecks++;
      if (state !== expSt[i]) begin nErrors++; $display("FAIL sw state[%0d]: got %0d want %0d", i, state, expSt[i]); end
      nChecks++;
      if (grfWe !== 1'b0) begin nErrors++; $display("FAIL sw grf_we[%0d]: got %b want 0", i, grfWe); end
      if (i == 3) begin
        nChecks++;
        if ({memReq, memIsInstr, memWe} !== 3'b101) begin
          nErrors++; $display("FAIL sw mem: got req/instr/we=%b want 101", {memReq, memIsInstr, memWe});
        end
      end
    end
  endtask

  task automatic test_reset_mid_sw();
    op = 6'h2B; funct = 6'h00; memReady = 1'b1;
    #1;
    nextCycle();
    nextCycle();
    nextCycle();
    memReady = 1'b0;
    #1;
    nChecks++;
    if ({state, memReq, memWe} !== {3'd3, 2'b11}) begin
      nErrors++; $display("FAIL midsw pre: got st=%0d req=%b we=%b want 3 1 1", state, memReq, memWe);
    end
    rstN = 1'b0;
    #1;
    nChecks++;
    if ({state, memReq, memWe} !== {3'd0, 2'b00}) begin
      nErrors++; $display("FAIL midsw abort: got st=%0d req=%b we=%b want 0 0 0", state, memReq, memWe);
    end
    nextCycle();
    rstN = 1'b1;
    #1;
    nChecks++;
    if ({state, memReq, memIsInstr} !== {3'd0, 2'b11}) begin
      nErrors++; $display("FAIL midsw release: got st=%0d req=%b instr=%b want 0 1 1", state, memReq, memIsInstr);
    end
  endtask

  task automatic test_beq();
    logic [2:0] expSt [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    for (int k = 0; k < 2; k++) begin
      op = 6'h04; funct = 6'h00; memReady = 1'b1; aluEqual = (k == 1);
      for (int i = 0; i < 4; i++) begin
        if (i > 0) nextCycle();
        #1;
        nChecks++;
        if (state !== expSt[i]) begin nErrors++; $display("FAIL beq eq=%0d state[%0d]: got %0d want %0d", k, i, state, expSt[i]); end
        if (i == 2) begin
          nChecks++;
          if (pcWe !== (k == 1)) begin nErrors++; $display("FAIL beq eq=%0d pc_we: got %b want %b", k, pcWe, (k == 1)); end
          nChecks++;
          if ({pcSel, aluCtrl, aluBSel, extSign} !== {2'd1, 5'd1, 1'b0, 1'b1}) begin
            nErrors++; $display("FAIL beq eq=%0d exec: got sel=%0d ctrl=%0d b=%b ext=%b want 1 1 0 1", k, pcSel, aluCtrl, aluBSel, extSign);
          end
        end
      end
    end
    aluEqual = 1'b0;
  endtask

  task automatic test_jump();
    logic [2:0] expSt [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin op = 6'h03; funct = 6'h00; end
      else begin op = 6'h00; funct = 6'h08; end
      memReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) nextCycle();
        #1;
        nChecks++;
        if (state !== expSt[i]) begin nErrors++; $display("FAIL jump k=%0d state[%0d]: got %0d want %0d", k, i, state, expSt[i]); end
        if (i == 2 && k == 0) begin
          nChecks++;
          if ({pcWe, pcSel, grfWe, grfWaSel, grfWdSel} !== 8'b1_10_1_10_10) begin
            nErrors++; $display("FAIL jal exec: got pcwe=%b sel=%0d gwe=%b wa=%0d wd=%0d want 1 2 1 2 2", pcWe, pcSel, grfWe, grfWaSel, grfWdSel);
          end
        end
        if (i == 2 && k == 1) begin
          nChecks++;
          if ({pcWe, pcSel, grfWe} !== 4'b1_11_0) begin
            nErrors++; $display("FAIL jr exec: got pcwe=%b sel=%0d gwe=%b want 1 3 0", pcWe, pcSel, grfWe);
          end
        end
      end
    end
  endtask

  task automatic test_nop();
    logic [2:0] expSt [3] = '{3'd0, 3'd1, 3'd0};
    op = 6'h00; funct = 6'h00; memReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nextCycle();
      #1;
      nChecks++;
      if (state !== expSt[i]) begin nErrors++; $display("FAIL nop state[%0d]: got %0d want %0d", i, state, expSt[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'h3F, 6'h00};
    logic [5:0] fns [2] = '{6'h00, 6'h22};
    for (int k = 0; k < 2; k++) begin
      op = ops[k]; funct = fns[k]; memReady = 1'b1;
      #1;
      nextCycle();
      #1;
      nChecks++;
      if ({state, illegal} !== {3'd1, 1'b0}) begin
        nErrors++; $display("FAIL illegal k=%0d decode: got st=%0d ill=%b want 1 0", k, state, illegal);
      end
      for (int i = 0; i < 3; i++) begin
        nextCycle();
        #1;
        nChecks++;
        if ({state, illegal, memReq, irWe, pcWe, grfWe} !== {3'd7, 5'b10000}) begin
          nErrors++; $display("FAIL illegal k=%0d trap[%0d]: got st=%0d ill=%b req=%b ir=%b pc=%b gwe=%b want 7 1 0 0 0 0",
                              k, i, state, illegal, memReq, irWe, pcWe, grfWe);
        end
      end
      rstN = 1'b0;
      #1;
      nChecks++;
      if ({state, illegal} !== {3'd0, 1'b0}) begin
        nErrors++; $display("FAIL illegal k=%0d reset: got st=%0d ill=%b want 0 0", k, state, illegal);
      end
      nextCycle();
      rstN = 1'b1;
    end
  endtask

  task automatic test_timeout();
    op = 6'h00; funct = 6'h21; memReady = 1'b0;
    rstN = 1'b0; rstN4 = 1'b0;
    nextCycle();
    rstN = 1'b1; rstN4 = 1'b1;
    #1;
    for (int k = 1; k <= 258; k++) begin
      nextCycle();
      #1;
      if (k == 3) begin
        nChecks++;
        if ({state4, timeout4, memReq4} !== {3'd0, 2'b01}) begin
          nErrors++; $display("FAIL wd4 before: got st=%0d to=%b req=%b want 0 0 1", state4, timeout4, memReq4);
        end
      end
      if (k == 4 || k == 6) begin
        nChecks++;
        if ({state4, timeout4, memReq4} !== {3'd7, 2'b10}) begin
          nErrors++; $display("FAIL wd4 after k=%0d: got st=%0d to=%b req=%b want 7 1 0", k, state4, timeout4, memReq4);
        end
      end
      if (k == 254) begin
        nChecks++;
        if ({state, timeout, memReq} !== {3'd0, 2'b01}) begin
          nErrors++; $display("FAIL wd255 before: got st=%0d to=%b req=%b want 0 0 1", state, timeout, memReq);
        end
      end
      if (k == 255 || k == 258) begin
        nChecks++;
        if ({state, timeout, memReq} !== {3'd7, 2'b10}) begin
          nErrors++; $display("FAIL wd255 after k=%0d: got st=%0d to=%b req=%b want 7 1 0", k, state, timeout, memReq);
        end
      end
      if (k == 256) memReady = 1'b1;
    end
  endtask

  initial begin
    rstN = 1'b0; rstN4 = 1'b0;
    op = 6'h00; funct = 6'h00; aluEqual = 1'b0; memReady = 1'b0;
    test_reset();
    test_addu();
    test_subu();
    test_imm();
    test_lw_wait();
    test_sw();
    test_reset_mid_sw();
    test_beq();
    test_jump();
    test_nop();
    test_illegal();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
